// File: rtl/abs_diff_acc_pkg.sv
// Shared constants for the abs-difference accumulator and the upstream subtractor.
package abs_diff_acc_pkg;

    localparam int BIT_DEF     = 32;
    localparam int VEC_LEN_DEF = 16;
    localparam int ACC_BIT_DEF = 40;

    // A one-sample vector still needs a 1-bit counter so the compare stays legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(VEC_LEN_DEF);

endpackage

// File: rtl/abs_diff_acc_abs_stage.sv
// Registered signed-to-magnitude stage; valid and a side flag ride along.
module abs_stage #(
    parameter int BIT = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush_i,
    input  logic           vld_i,
    input  logic           last_i,
    input  logic [BIT-1:0] d_i,
    output logic           vld_o,
    output logic           last_o,
    output logic [BIT-1:0] mag_o
);

    logic [BIT-1:0] mag_d, mag_q;
    logic           vld_q, last_q;

    // Most negative input maps to 2^(BIT-1), which fits as an unsigned BIT-bit value.
    assign mag_d = d_i[BIT-1] ? (~d_i + BIT'(1)) : d_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            mag_q  <= '0;
        end else begin
            vld_q  <= vld_i & ~flush_i;
            last_q <= last_i;
            mag_q  <= mag_d;
        end
    end

    assign vld_o  = vld_q;
    assign last_o = last_q;
    assign mag_o  = mag_q;

endmodule

// File: rtl/abs_diff_acc.sv
// Accumulates |D_in| over VEC_LEN-sample vectors and emits one saturating L1 sum per vector.
module abs_diff_acc
    import abs_diff_acc_pkg::*;
#(
    parameter int BIT     = BIT_DEF,
    parameter int VEC_LEN = VEC_LEN_DEF,
    parameter int ACC_BIT = ACC_BIT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               data_in_valid,
    input  logic [BIT-1:0]     D_in,
    output logic               data_out_valid,
    output logic [ACC_BIT-1:0] sum_out,
    output logic               sat_out,
    output logic               busy
);

    localparam int CNT_W = cnt_width(VEC_LEN);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept, last_in;
    logic               s1_vld, s1_last;
    logic [BIT-1:0]     s1_mag;
    logic [ACC_BIT-1:0] mag_ext;
    logic [ACC_BIT:0]   sum_wide;

    logic [ACC_BIT-1:0] acc_q, acc_d, sum_q, sum_d;
    logic               sat_q, sat_d, sato_q, sato_d;
    logic               first_q, first_d, ovld_q, ovld_d;

    assign accept  = data_in_valid & ~clear;
    assign last_in = (cnt_q == CNT_W'(VEC_LEN - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (accept)
            cnt_d = last_in ? '0 : cnt_q + 1'b1;
    end

    abs_stage #(.BIT(BIT)) u_abs (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (clear),
        .vld_i   (accept),
        .last_i  (last_in),
        .d_i     (D_in),
        .vld_o   (s1_vld),
        .last_o  (s1_last),
        .mag_o   (s1_mag)
    );

    assign mag_ext  = ACC_BIT'(s1_mag);
    assign sum_wide = {1'b0, acc_q} + {1'b0, mag_ext};

    // first_q marks that the next stage-1 sample starts a vector (load instead of add).
    always_comb begin
        acc_d   = acc_q;
        sat_d   = sat_q;
        first_d = first_q;
        ovld_d  = 1'b0;
        sum_d   = sum_q;
        sato_d  = sato_q;
        if (clear) begin
            acc_d   = '0;
            sat_d   = 1'b0;
            first_d = 1'b1;
        end else if (s1_vld) begin
            if (first_q) begin
                acc_d = mag_ext;
                sat_d = 1'b0;
            end else if (sum_wide[ACC_BIT]) begin
                acc_d = '1;
                sat_d = 1'b1;
            end else begin
                acc_d = sum_wide[ACC_BIT-1:0];
            end
            first_d = s1_last;
            if (s1_last) begin
                ovld_d = 1'b1;
                sum_d  = acc_d;
                sato_d = sat_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            first_q <= 1'b1;
            ovld_q  <= 1'b0;
            sum_q   <= '0;
            sato_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            first_q <= first_d;
            ovld_q  <= ovld_d;
            sum_q   <= sum_d;
            sato_q  <= sato_d;
        end
    end

    assign data_out_valid = ovld_q;
    assign sum_out        = sum_q;
    assign sat_out        = sato_q;
    assign busy           = (cnt_q != '0) | s1_vld | ~first_q;

endmodule

// File: tb/tb_abs_diff_acc.sv
// Directed bench for abs_diff_acc: three configurations, scoreboard queues checked on each pulse.
module tb_abs_diff_acc;

    typedef struct {
        logic [39:0] sum;
        logic        sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    logic        v32 = 1'b0, v8 = 1'b0, v1 = 1'b0;
    logic [31:0] d32 = '0;
    logic [7:0]  d8 = '0, d1 = '0;

    logic        o32, o8, o1, sat32, sat8, sat1, busy32, busy8, busy1;
    logic [39:0] sum32;
    logic [8:0]  sum8;
    logic [7:0]  sum1;

    exp_t q32[$], q8[$], q1[$];
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    abs_diff_acc #(.BIT(32), .VEC_LEN(4), .ACC_BIT(40)) dut32 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .data_in_valid(v32), .D_in(d32),
        .data_out_valid(o32), .sum_out(sum32), .sat_out(sat32), .busy(busy32));

    abs_diff_acc #(.BIT(8), .VEC_LEN(4), .ACC_BIT(9)) dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .data_in_valid(v8), .D_in(d8),
        .data_out_valid(o8), .sum_out(sum8), .sat_out(sat8), .busy(busy8));

    abs_diff_acc #(.BIT(8), .VEC_LEN(1), .ACC_BIT(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .data_in_valid(v1), .D_in(d1),
        .data_out_valid(o1), .sum_out(sum1), .sat_out(sat1), .busy(busy1));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic push(input int which, input logic [39:0] s, input logic sat);
        exp_t e;
        e.sum = s;
        e.sat = sat;
        if (which == 32) q32.push_back(e);
        else if (which == 8) q8.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic drv32(input logic v, input logic [31:0] d);
        @(negedge clk);
        v32 = v; d32 = d;
    endtask

    task automatic drv8(input logic v, input logic [7:0] d);
        @(negedge clk);
        v8 = v; d8 = d;
    endtask

    task automatic vec32(input logic [31:0] a0, a1, a2, a3, input logic [39:0] esum,
                         input logic esat, input int maxgap);
        logic [31:0] s[4];
        s = '{a0, a1, a2, a3};
        push(32, esum, esat);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(maxgap, 0)) drv32(1'b0, 32'd0);
            drv32(1'b1, s[i]);
        end
    endtask

    task automatic vec8(input logic [7:0] a0, a1, a2, a3, input logic [39:0] esum, input logic esat);
        logic [7:0] s[4];
        s = '{a0, a1, a2, a3};
        push(8, esum, esat);
        for (int i = 0; i < 4; i++) drv8(1'b1, s[i]);
        drv8(1'b0, 8'd0);
    endtask

    exp_t e32, e8, e1;
    always @(negedge clk) begin
        if (o32) begin
            if (q32.size() == 0) chk("dut32 unexpected pulse", 64'd1, 64'd0);
            else begin
                e32 = q32.pop_front();
                chk("dut32 sum", 64'(sum32), 64'(e32.sum));
                chk("dut32 sat", 64'(sat32), 64'(e32.sat));
            end
        end
        if (o8) begin
            if (q8.size() == 0) chk("dut8 unexpected pulse", 64'd1, 64'd0);
            else begin
                e8 = q8.pop_front();
                chk("dut8 sum", 64'(sum8), 64'(e8.sum));
                chk("dut8 sat", 64'(sat8), 64'(e8.sat));
            end
        end
        if (o1) begin
            if (q1.size() == 0) chk("dut1 unexpected pulse", 64'd1, 64'd0);
            else begin
                e1 = q1.pop_front();
                chk("dut1 sum", 64'(sum1), 64'(e1.sum));
                chk("dut1 sat", 64'(sat1), 64'(e1.sat));
            end
        end
    end

    initial begin
        #12;
        chk("reset valid", 64'(o32), 64'd0);
        chk("reset sum", 64'(sum32), 64'd0);
        chk("reset sat", 64'(sat32), 64'd0);
        chk("reset busy", 64'(busy32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic vector with exact two-cycle latency after the last sample.
        vec32(32'd3, -32'sd5, 32'd7, -32'sd1, 40'd16, 1'b0, 0);
        drv32(1'b0, 32'd0);
        chk("latency not early", 64'(o32), 64'd0);
        @(negedge clk);
        chk("latency pulse", 64'(o32), 64'd1);
        chk("busy idle after pulse", 64'(busy32), 64'd0);

        // Most negative input.
        vec32(32'h8000_0000, 32'd0, 32'd0, 32'd0, 40'd2147483648, 1'b0, 0);
        drv32(1'b0, 32'd0);
        repeat (3) @(negedge clk);

        // Saturation on a narrow accumulator, then recovery on the next vector.
        vec8(8'h80, 8'h80, 8'h80, 8'h80, 40'd511, 1'b1);
        vec8(8'd1, 8'd1, 8'd1, 8'd1, 40'd4, 1'b0);
        repeat (3) @(negedge clk);

        // Single-sample vectors: every sample is a vector.
        push(1, 40'd128, 1'b0);
        push(1, 40'd5, 1'b0);
        @(negedge clk); v1 = 1'b1; d1 = 8'h80;
        @(negedge clk); d1 = 8'hfb;
        @(negedge clk); v1 = 1'b0;
        repeat (3) @(negedge clk);

        // Back-to-back vectors, then the same stream with random gaps.
        vec32(32'd1, 32'd2, 32'd3, 32'd4, 40'd10, 1'b0, 0);
        vec32(32'd10, 32'd10, 32'd10, 32'd10, 40'd40, 1'b0, 0);
        vec32(32'd1, 32'd2, 32'd3, 32'd4, 40'd10, 1'b0, 2);
        vec32(32'd10, 32'd10, 32'd10, 32'd10, 40'd40, 1'b0, 2);
        drv32(1'b0, 32'd0);
        repeat (3) @(negedge clk);

        // Clear mid-vector with a sample presented alongside it.
        drv32(1'b1, 32'd5);
        drv32(1'b1, 32'd5);
        @(negedge clk); clear = 1'b1; v32 = 1'b1; d32 = 32'd100;
        chk("busy before clear", 64'(busy32), 64'd1);
        @(negedge clk); clear = 1'b0; v32 = 1'b0;
        chk("busy after clear", 64'(busy32), 64'd0);
        chk("sum held over clear", 64'(sum32), 64'd40);
        vec32(32'd1, 32'd1, 32'd1, 32'd1, 40'd4, 1'b0, 0);
        drv32(1'b0, 32'd0);
        repeat (3) @(negedge clk);

        // Clear while the last sample sits in stage 1: no pulse may appear.
        for (int i = 0; i < 4; i++) drv32(1'b1, 32'd7);
        @(negedge clk); clear = 1'b1; v32 = 1'b0;
        @(negedge clk); clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("sum held after dropped vector", 64'(sum32), 64'd4);

        // Reset mid-vector.
        drv32(1'b1, 32'd9);
        drv32(1'b1, 32'd9);
        @(negedge clk); v32 = 1'b0; rst_n = 1'b0;
        #1;
        chk("mid reset valid", 64'(o32), 64'd0);
        chk("mid reset sum", 64'(sum32), 64'd0);
        chk("mid reset sat", 64'(sat32), 64'd0);
        chk("mid reset busy", 64'(busy32), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        vec32(32'd2, 32'd2, 32'd2, 32'd2, 40'd8, 1'b0, 0);
        drv32(1'b0, 32'd0);
        repeat (3) @(negedge clk);
        chk("busy after final pulse", 64'(busy32), 64'd0);

        chk("dut32 all pulses seen", 64'(q32.size()), 64'd0);
        chk("dut8 all pulses seen", 64'(q8.size()), 64'd0);
        chk("dut1 all pulses seen", 64'(q1.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
